clock_divider_bank: RTL and testbench
=====================================

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 24: width of the per-channel half-period count.
REQ-003 SHALL have parameter RST_HALF, default 2**(DIV_W-1): half-period count loaded into every channel at reset.
REQ-004 SHALL have port ref_clk, input, 1: rising-edge clock for all logic.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, NUM_CH: per-channel run enable.
REQ-007 SHALL have port cfg_valid, input, 1: configuration write request.
REQ-008 SHALL have port cfg_ready, output, 1: configuration write can be accepted.
REQ-009 SHALL have port cfg_ch, input, 3: target channel index.
REQ-010 SHALL have port cfg_half, input, DIV_W: new half-period count, in ref_clk cycles.
REQ-011 SHALL have port clk_out, output, NUM_CH: divided clocks, registered, 50% duty.
REQ-012 SHALL have port tick, output, NUM_CH: one-cycle strobe on each clk_out 0->1 transition.
REQ-013 SHALL have port pending, output, NUM_CH: shadow value waiting to be applied.

Function
REQ-014 Each channel SHALL hold an active half count (half), a shadow count, a DIV_W counter (cnt), a pending flag and a clk_out flop.
REQ-015 A half value of 0 SHALL be treated as 1.
REQ-016 With en=1, cnt SHALL increment each cycle; at cnt==half-1, cnt SHALL wrap to 0 and clk_out SHALL toggle on the same edge.
REQ-017 Output period SHALL therefore be 2*half ref_clk cycles, high for half cycles and low for half cycles.
REQ-018 tick SHALL be 1 exactly in the cycle in which clk_out first reads 1 after a 0->1 toggle; otherwise tick SHALL be 0.
REQ-019 With en=0, the channel SHALL synchronously clear cnt to 0 and clk_out to 0, and SHALL hold tick at 0.
REQ-020 When en rises, the first 0->1 toggle SHALL occur half cycles after the first enabled edge.
REQ-021 A write SHALL be accepted on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-022 cfg_ready SHALL equal !pending[cfg_ch] for in-range cfg_ch and 1 otherwise.
REQ-023 An accepted write to cfg_ch>=NUM_CH SHALL be acknowledged and discarded.
REQ-024 An accepted in-range write SHALL load the shadow count and set pending on the next edge.
REQ-025 On an enabled channel, the shadow SHALL transfer to half, and pending SHALL clear, on the edge where clk_out toggles 0->1, so the new ratio starts at a period boundary without a runt pulse.
REQ-026 On a disabled channel, the shadow SHALL transfer on the edge after acceptance.
REQ-027 If an apply edge coincides with a new accepted write to the same channel, the apply SHALL take priority, and the new write SHALL be impossible because cfg_ready=0.
REQ-028 Channels SHALL be fully independent, and simultaneous toggles SHALL be permitted.

Reset
REQ-029 On rst=0, every output SHALL go low asynchronously: clk_out=0, tick=0, pending=0.
REQ-030 On rst=0, cnt SHALL go to 0, and half and shadow SHALL go to RST_HALF.
REQ-031 cfg_ready SHALL read 1 in reset.
REQ-032 Reset asserted mid-period SHALL discard any pending shadow.
REQ-033 After reset release, channels with en=1 SHALL begin counting on the first ref_clk edge.

Structure
REQ-034 A shared package SHALL hold MAX_CH=8, the channel-index width (3) and a constant for the zero-to-one substitution.
REQ-035 One sub-module, clock_divider_channel, SHALL contain a single channel (counter, shadow, pending, toggle, tick), instantiated NUM_CH times by generate.
REQ-036 Config decode and cfg_ready muxing SHALL reside in the top level.

Verification
REQ-037 Reset/basic: NUM_CH=2, DIV_W=8, RST_HALF=4, en=2'b11 after reset -> both clk_out have period 8, high 4/low 4, and tick pulses every 8 cycles.
REQ-038 Ratio update: write ch0 half=3 mid-high-phase -> pending[0]=1 and cfg_ready=0 for that ch; the change applies at the next 0->1 edge; the following periods are 6; no pulse is shorter than 3 cycles.
REQ-039 Zero and one: write half=0, then half=1 -> clk_out toggles every cycle (period 2) in both cases, and tick fires every 2 cycles.
REQ-040 Enable control: drop en[1] while clk_out[1]=1 -> next cycle clk_out[1]=0 with no tick; re-raise en[1] -> first rising edge after 4 cycles.
REQ-041 Handshake edges: back-to-back writes to ch0 -> the second stalls until apply; a write to cfg_ch=5 -> accepted with no state change; simultaneous writes to ch1 while ch0 is pending -> accepted.
REQ-042 Async reset mid-operation: assert rst with pending[0]=1 and clk_out high -> all outputs 0 immediately; after release the period is 2*RST_HALF.

Source files
------------

// File: rtl/clock_divider_bank_pkg.sv
// Shared constants for the clock divider bank and its channels.
package clock_divider_bank_pkg;

    // Upper bound on channel count; also the range of the channel index.
    localparam int MAX_CH        = 8;
    localparam int CH_IDX_W      = 3;

    // A programmed half count of zero runs as if it were this value.
    localparam int HALF_ZERO_SUB = 1;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, 50% toggle output, rising-edge
// strobe, and a shadow half count that is applied only at a 0->1 boundary
// while running (or on the next edge while stopped) so no runt pulse appears.
module clock_divider_channel
    import clock_divider_bank_pkg::*;
#(
    parameter int               DIV_W    = 24,
    parameter logic [DIV_W-1:0] RST_HALF = {1'b1, {(DIV_W-1){1'b0}}}
)
(
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] r_half;
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_pending;

    logic [DIV_W-1:0] w_half_eff;
    logic             w_term;
    logic             w_rise;

    assign w_half_eff = (r_half == '0) ? DIV_W'(HALF_ZERO_SUB) : r_half;
    assign w_term     = (r_cnt == (w_half_eff - DIV_W'(1)));
    assign w_rise     = en & w_term & ~r_clk_out;

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign pending = r_pending;

    // Count the half period, toggle the output at terminal count, strobe on 0->1.
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!en) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_rise;
            if (w_term) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    // Capture new half counts into the shadow and apply them at a period boundary.
    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            r_half    <= RST_HALF;
            r_shadow  <= RST_HALF;
            r_pending <= 1'b0;
        end else if (r_pending && (w_rise || !en)) begin
            r_half    <= r_shadow;
            r_pending <= 1'b0;
        end else if (wr_en) begin
            r_shadow  <= wr_half;
            r_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent 50%-duty clock dividers sharing one configuration port.
// A channel with a pending shadow value refuses further writes until it applies.
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int          NUM_CH   = 2,
    parameter int          DIV_W    = 24,
    parameter int unsigned RST_HALF = 2**(DIV_W-1)
)
(
    input  logic                ref_clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_half,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pending
);

    logic [MAX_CH-1:0] w_pending_ext;
    logic              w_accept;
    logic [NUM_CH-1:0] w_wr;

    // Widen pending to the full index range; unused channels read as never pending.
    always_comb begin
        w_pending_ext             = '0;
        w_pending_ext[NUM_CH-1:0] = pending;
    end

    assign cfg_ready = ~w_pending_ext[cfg_ch];
    assign w_accept  = cfg_valid & cfg_ready;

    // Decode an accepted write to a per-channel load strobe; out-of-range is dropped.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = w_accept && (cfg_ch == CH_IDX_W'(i));
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            clock_divider_channel #(
                .DIV_W    (DIV_W),
                .RST_HALF (DIV_W'(RST_HALF))
            ) u_ch (
                .ref_clk (ref_clk),
                .rst     (rst),
                .en      (en[g]),
                .wr_en   (w_wr[g]),
                .wr_half (cfg_half),
                .clk_out (clk_out[g]),
                .tick    (tick[g]),
                .pending (pending[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench: stimulus pushes hand-computed clk_out edge times per channel
// into queues; a negedge monitor pops and compares on every observed edge and
// checks that tick coincides exactly with 0->1 transitions.
module tb_clock_divider_bank;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;

    logic              ref_clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q0[$];
    int exp_q1[$];
    logic [NUM_CH-1:0] prev_clk = '0;

    clock_divider_bank #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .RST_HALF (4)
    ) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected edge encoded as cycle*2 + level.
    task automatic push_e(input int ch, input int c, input int lvl);
        if (ch == 0) exp_q0.push_back(c * 2 + lvl);
        else         exp_q1.push_back(c * 2 + lvl);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge ref_clk);
    endtask

    // Holds cfg_valid until accepted; returns at the negedge after acceptance.
    task automatic cfg_write(input int ch, input int h, output int acc);
        bit done;
        done      = 0;
        acc       = -1;
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_half  = 8'(h);
        #1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (cfg_ready) done = 1;
            @(negedge ref_clk);
            #1;
        end
        if (done) acc = cyc;
        else chk("cfg_write_timeout", 0, 1);
    endtask

    // Monitor: compare every clk_out edge against the expected queue, and tick vs 0->1.
    always @(negedge ref_clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (clk_out[ch] != prev_clk[ch]) begin
                int got;
                int want;
                got = cyc * 2 + int'(clk_out[ch]);
                if (ch == 0) want = (exp_q0.size() > 0) ? exp_q0.pop_front() : -1;
                else         want = (exp_q1.size() > 0) ? exp_q1.pop_front() : -1;
                checks++;
                if (got != want) begin
                    errors++;
                    $display("FAIL edge ch%0d: got cycle %0d level %0d, expected cycle %0d level %0d",
                             ch, cyc, clk_out[ch], want / 2, want % 2);
                end
            end
            if (tick[ch] || (clk_out[ch] && !prev_clk[ch])) begin
                checks++;
                if (tick[ch] != (clk_out[ch] && !prev_clk[ch])) begin
                    errors++;
                    $display("FAIL tick ch%0d at cycle %0d: tick %0d, rise %0d",
                             ch, cyc, tick[ch], clk_out[ch] && !prev_clk[ch]);
                end
            end
        end
        prev_clk <= clk_out;
    end

    initial begin
        int a;
        rst       = 1'b0;
        en        = 2'b11;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_half  = 8'd0;

        // Both channels run at half 4 after reset release at cycle 3.
        for (int c = 7; c <= 19; c += 4) push_e(0, c, ((c - 7) % 8 == 0) ? 1 : 0);
        for (int c = 7; c <= 31; c += 4) push_e(1, c, ((c - 7) % 8 == 0) ? 1 : 0);

        wait_cyc(2);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        wait_cyc(3);
        rst = 1'b1;

        // Ratio update on ch0 mid-high: applies at the rise on cycle 23.
        wait_cyc(16);
        push_e(0, 23, 1); push_e(0, 26, 0); push_e(0, 29, 1);
        push_e(0, 32, 0); push_e(0, 35, 1); push_e(0, 38, 0);
        cfg_write(0, 3, a);
        cfg_valid = 1'b0;
        chk("b_accept_cycle", a, 17);
        chk("b_pending", int'(pending), 1);
        chk("b_cfg_ready", int'(cfg_ready), 0);
        wait_cyc(22);
        chk("b_pending_hold", int'(pending[0]), 1);
        wait_cyc(23);
        chk("b_pending_apply", int'(pending[0]), 0);

        // Enable control on ch1: drop while high, re-raise four cycles later.
        wait_cyc(32);
        push_e(1, 33, 0);
        for (int c = 40; c <= 64; c += 4) push_e(1, c, ((c - 40) % 8 == 0) ? 1 : 0);
        en[1] = 1'b0;
        wait_cyc(36);
        en[1] = 1'b1;

        // Half 0 then half 1 on ch0: both give period 2.
        push_e(0, 41, 1);
        for (int c = 42; c <= 53; c++) push_e(0, c, c % 2);
        cfg_write(0, 0, a);
        cfg_valid = 1'b0;
        chk("c_pending0", int'(pending[0]), 1);
        wait_cyc(41);
        chk("c_apply0", int'(pending[0]), 0);
        wait_cyc(42);
        cfg_write(0, 1, a);
        cfg_valid = 1'b0;
        wait_cyc(44);
        chk("c_pending1", int'(pending[0]), 1);
        wait_cyc(45);
        chk("c_apply1", int'(pending[0]), 0);

        // Back-to-back writes to ch0: second stalls until the apply at cycle 53.
        wait_cyc(50);
        push_e(0, 57, 0); push_e(0, 61, 1); push_e(0, 63, 0); push_e(0, 65, 1);
        push_e(0, 67, 0); push_e(0, 69, 1); push_e(0, 71, 0); push_e(0, 73, 1);
        cfg_write(0, 4, a);
        chk("d_first_accept", a, 51);
        chk("d_ready_stall", int'(cfg_ready), 0);
        cfg_write(0, 2, a);
        cfg_valid = 1'b0;
        chk("d_second_accept", a, 54);
        chk("d_pending", int'(pending[0]), 1);

        // Out-of-range write is acknowledged and dropped; ch1 write accepted while ch0 pending.
        wait_cyc(55);
        cfg_ch = 3'd5;
        #1;
        chk("e_ready_oor", int'(cfg_ready), 1);
        cfg_write(5, 7, a);
        chk("e_oor_accept", a, 56);
        chk("e_oor_nochange", int'(pending), 1);
        push_e(1, 66, 0); push_e(1, 68, 1); push_e(1, 70, 0);
        push_e(1, 72, 1); push_e(1, 74, 0);
        cfg_write(1, 2, a);
        cfg_valid = 1'b0;
        chk("e_ch1_accept", a, 57);
        chk("e_both_pending", int'(pending), 3);

        // Async reset while ch0 is high with a pending shadow.
        wait_cyc(73);
        push_e(0, 75, 0);
        push_e(0, 80, 1); push_e(0, 84, 0); push_e(0, 88, 1); push_e(0, 92, 0);
        push_e(1, 80, 1); push_e(1, 84, 0); push_e(1, 88, 1); push_e(1, 92, 0);
        cfg_write(0, 5, a);
        cfg_valid = 1'b0;
        chk("f_pending_before", int'(pending[0]), 1);
        chk("f_high_before", int'(clk_out[0]), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("f_rst_clk_out", int'(clk_out), 0);
        chk("f_rst_tick", int'(tick), 0);
        chk("f_rst_pending", int'(pending), 0);
        chk("f_rst_ready", int'(cfg_ready), 1);
        wait_cyc(76);
        rst = 1'b1;
        wait_cyc(77);
        chk("f_pending_after", int'(pending), 0);
        wait_cyc(93);
        en = 2'b00;

        wait_cyc(100);
        chk("left_in_q0", exp_q0.size(), 0);
        chk("left_in_q1", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
